// File: rtl/ebi_read_responder_if.sv
// EBI read-side bus bundle: MCU pad signals plus the memory read port.
// slave = responder view, master = MCU/memory view.
interface ebi_read_responder_if;
    logic [15:0] EBI_AD;
    logic        EBI_ALE;
    logic        EBI_RE;
    logic [15:0] ebi_ad_out;
    logic        ebi_ad_oe;
    logic        mem_rd_en;
    logic [14:0] mem_rd_addr;
    logic [15:0] mem_rd_data;

    modport slave (
        input  EBI_AD, EBI_ALE, EBI_RE, mem_rd_data,
        output ebi_ad_out, ebi_ad_oe, mem_rd_en, mem_rd_addr
    );

    modport master (
        output EBI_AD, EBI_ALE, EBI_RE, mem_rd_data,
        input  ebi_ad_out, ebi_ad_oe, mem_rd_en, mem_rd_addr
    );
endinterface

// File: rtl/ebi_read_responder.sv
// EBI read responder: latches address on ALE fall, fetches a word on RE fall, drives it until RE rise.
// Optional EBI_READ_AUTOINC_EN: post-increment addr_q[14:0] after every completed read.
module ebi_read_responder #(
    parameter int          SYNC_STAGES = 2,
    parameter int          MEM_LATENCY = 1,
    parameter logic [15:0] ID_WORD     = 16'h4D4E
) (
    input  logic                 clk,
    input  logic                 reset,
    ebi_read_responder_if.slave  bus,
    input  logic [9:0]           line_y,
    input  logic                 vblank,
    input  logic                 frame_tick
);

    typedef enum logic [1:0] {IDLE, ADDR, FETCH, DRIVE} state_t;

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    state_t                 state;
    logic [SYNC_STAGES-1:0] ale_s;
    logic [SYNC_STAGES-1:0] re_s;
    logic                   ale_fall, ale_rise, re_fall, re_rise;
    logic [15:0]            addr_q;
    logic [15:0]            frame_cnt;
    logic [15:0]            status_word;
    logic [15:0]            ad_out;
    logic                   ad_oe;
    logic                   rd_en;
    logic [14:0]            rd_addr;
    logic [2:0]             lat_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            ale_s <= '0;
            re_s  <= '1;
        end else begin
            ale_s <= {ale_s[SYNC_STAGES-2:0], bus.EBI_ALE};
            re_s  <= {re_s[SYNC_STAGES-2:0], bus.EBI_RE};
        end
    end

    // Edges compare the last two synchroniser stages (index N-2 is the newer sample).
    assign ale_fall = ale_s[SYNC_STAGES-1] & ~ale_s[SYNC_STAGES-2];
    assign ale_rise = ~ale_s[SYNC_STAGES-1] & ale_s[SYNC_STAGES-2];
    assign re_fall  = re_s[SYNC_STAGES-1] & ~re_s[SYNC_STAGES-2];
    assign re_rise  = ~re_s[SYNC_STAGES-1] & re_s[SYNC_STAGES-2];

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    always_comb begin
        status_word = '0;
        case (addr_q[1:0])
            2'd0:    status_word = frame_cnt;
            2'd1:    status_word = {6'b0, line_y};
            2'd2:    status_word = {15'b0, vblank};
            default: status_word = ID_WORD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            ad_out  <= '0;
            ad_oe   <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            lat_cnt <= '0;
        end else begin
            rd_en <= 1'b0;
            case (state)
                IDLE, ADDR: begin
                    if (ale_fall) begin
                        addr_q <= bus.EBI_AD;
                        state  <= ADDR;
                    end else if (re_fall) begin
                        state   <= FETCH;
                        lat_cnt <= '0;
                        if (!addr_q[15]) begin
                            rd_en   <= 1'b1;
                            rd_addr <= addr_q[14:0];
                        end
                    end
                end
                FETCH: begin
                    if (ale_rise) begin
                        state <= IDLE;
                    end else if (re_rise) begin
                        // Strobe ended before data was ready: drop the read without driving.
                        state <= ADDR;
                    end else if (addr_q[15]) begin
                        ad_out <= status_word;
                        ad_oe  <= 1'b1;
                        state  <= DRIVE;
                    end else if (lat_cnt == LAT) begin
                        ad_out <= bus.mem_rd_data;
                        ad_oe  <= 1'b1;
                        state  <= DRIVE;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                DRIVE: begin
                    if (ale_rise) begin
                        ad_oe <= 1'b0;
                        state <= IDLE;
                    end else if (re_rise) begin
                        ad_oe <= 1'b0;
                        state <= ADDR;
`ifdef EBI_READ_AUTOINC_EN
                        addr_q <= {addr_q[15], addr_q[14:0] + 15'd1};
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ebi_ad_out  = ad_out;
    assign bus.ebi_ad_oe   = ad_oe;
    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_rd_addr = rd_addr;

endmodule

// File: tb/tb_ebi_read_responder.sv
// Directed bench for ebi_read_responder with a one-cycle-latency memory model.
module tb_ebi_read_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] line_y;
    logic       vblank;
    logic       frame_tick;
    int         vectors = 0;
    int         miscompares = 0;
    int         en_cnt = 0;
    logic [14:0] en_addr = '0;

    always #5 clk = ~clk;

    ebi_read_responder_if bus ();

    ebi_read_responder #(
        .SYNC_STAGES (2),
        .MEM_LATENCY (1),
        .ID_WORD     (16'h4D4E)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .line_y     (line_y),
        .vblank     (vblank),
        .frame_tick (frame_tick)
    );

    function automatic logic [15:0] mem_f(input logic [14:0] a);
        if (a == 15'h0123) return 16'hBEEF;
        return {1'b0, a} ^ 16'h5A5A;
    endfunction

    // Memory returns data one cycle after the request, garbage otherwise.
    always @(posedge clk) begin
        bus.mem_rd_data <= bus.mem_rd_en ? mem_f(bus.mem_rd_addr) : 16'hDEAD;
    end

    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            en_cnt  <= en_cnt + 1;
            en_addr <= bus.mem_rd_addr;
        end
    end

    task automatic do_reset();
        reset        = 1'b1;
        bus.EBI_ALE  = 1'b0;
        bus.EBI_RE   = 1'b1;
        bus.EBI_AD   = 16'h0000;
        frame_tick   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic latch_addr(input logic [15:0] a);
        @(negedge clk);
        bus.EBI_AD  = a;
        bus.EBI_ALE = 1'b1;
        repeat (3) @(negedge clk);
        bus.EBI_ALE = 1'b0;
        repeat (3) @(negedge clk);
        bus.EBI_AD = 16'hFFFF;
        repeat (2) @(negedge clk);
    endtask

    // One RE strobe of 10 cycles; optional frame_tick on cycle tick_at.
    task automatic re_strobe(input int tick_at, output logic [15:0] data, output int lat,
                             output logic stable, output logic oe_hold, output logic oe_after);
        data   = '0;
        lat    = 0;
        stable = 1'b1;
        bus.EBI_RE = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            frame_tick = (k == tick_at);
            @(negedge clk);
            if (bus.ebi_ad_oe) begin
                if (lat == 0) begin
                    lat  = k;
                    data = bus.ebi_ad_out;
                end else if (bus.ebi_ad_out !== data) begin
                    stable = 1'b0;
                end
            end
        end
        frame_tick = 1'b0;
        bus.EBI_RE = 1'b1;
        @(negedge clk);
        oe_hold = bus.ebi_ad_oe;
        repeat (2) @(negedge clk);
        oe_after = bus.ebi_ad_oe;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.ebi_ad_oe !== 1'b0 || bus.mem_rd_en !== 1'b0 || bus.ebi_ad_out !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: oe=%b en=%b out=%h, expected 0/0/0000",
                         i, bus.ebi_ad_oe, bus.mem_rd_en, bus.ebi_ad_out);
            end
        end
        vectors++;
        if (en_cnt !== 0) begin
            miscompares++;
            $display("FAIL reset_no_req: mem_rd_en pulses=%0d, expected 0", en_cnt);
        end
    endtask

    task automatic test_idle_read();
        logic [15:0] d;
        int          lat;
        logic        st, oh, oa;
        int          n0;
        do_reset();
        n0 = en_cnt;
        re_strobe(0, d, lat, st, oh, oa);
        vectors++;
        if (en_cnt !== n0 + 1 || en_addr !== 15'h0000) begin
            miscompares++;
            $display("FAIL idle_read_req: pulses=%0d addr=%h, expected 1 at 0000", en_cnt - n0, en_addr);
        end
        vectors++;
        if (d !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL idle_read_data: got %h, expected 5a5a", d);
        end
    endtask

    task automatic test_mem_read();
        logic [15:0] d;
        int          lat;
        logic        st, oh, oa;
        int          n0;
        latch_addr(16'h0123);
        n0 = en_cnt;
        re_strobe(0, d, lat, st, oh, oa);
        vectors++;
        if (en_cnt !== n0 + 1 || en_addr !== 15'h0123) begin
            miscompares++;
            $display("FAIL mem_req: pulses=%0d addr=%h, expected 1 at 0123", en_cnt - n0, en_addr);
        end
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL mem_latency: oe after %0d cycles, expected 4", lat);
        end
        vectors++;
        if (d !== 16'hBEEF || st !== 1'b1) begin
            miscompares++;
            $display("FAIL mem_data: got %h stable=%b, expected beef stable=1", d, st);
        end
        vectors++;
        if (oh !== 1'b1 || oa !== 1'b0) begin
            miscompares++;
            $display("FAIL mem_release: oe 1 cycle after RE rise=%b, 3 cycles after=%b, expected 1/0", oh, oa);
        end
    endtask

    task automatic test_status();
        logic [15:0] addrs [4] = '{16'h8000, 16'h8003, 16'h8001, 16'h8002};
        logic [15:0] exps  [4] = '{16'h0003, 16'h4D4E, 16'h01E1, 16'h0001};
        logic [15:0] d;
        int          lat;
        logic        st, oh, oa;
        int          n0;
        do_reset();
        line_y = 10'd481;
        vblank = 1'b1;
        for (int i = 0; i < 3; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
        n0 = en_cnt;
        for (int i = 0; i < 4; i++) begin
            latch_addr(addrs[i]);
            re_strobe(0, d, lat, st, oh, oa);
            vectors++;
            if (d !== exps[i] || lat !== 3) begin
                miscompares++;
                $display("FAIL status_%h: got %h after %0d cycles, expected %h after 3",
                         addrs[i], d, lat, exps[i]);
            end
        end
        vectors++;
        if (en_cnt !== n0) begin
            miscompares++;
            $display("FAIL status_no_mem: %0d memory requests, expected 0", en_cnt - n0);
        end
    endtask

    task automatic test_frame_wrap();
        logic [15:0] d;
        int          lat;
        logic        st, oh, oa;
        do_reset();
        frame_tick = 1'b1;
        repeat (65535) @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        latch_addr(16'h8000);
        re_strobe(3, d, lat, st, oh, oa);
        vectors++;
        if (d !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL frame_coincident: got %h, expected ffff", d);
        end
        latch_addr(16'h8000);
        re_strobe(0, d, lat, st, oh, oa);
        vectors++;
        if (d !== 16'h0000) begin
            miscompares++;
            $display("FAIL frame_wrap: got %h, expected 0000", d);
        end
    endtask

    task automatic test_abort();
        logic got;
        logic oe_ok;
        int   n0;
        latch_addr(16'h0040);
        bus.EBI_RE = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = bus.ebi_ad_oe;
        end
        vectors++;
        if (got !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_setup: oe never rose, expected 1");
        end
        n0 = en_cnt;
        bus.EBI_AD  = 16'h1111;
        bus.EBI_ALE = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.ebi_ad_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_oe: oe=%b, expected 0", bus.ebi_ad_oe);
        end
        oe_ok = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.ebi_ad_oe !== 1'b0) oe_ok = 1'b0;
        end
        vectors++;
        if (oe_ok !== 1'b1 || en_cnt !== n0) begin
            miscompares++;
            $display("FAIL abort_quiet: oe_stayed_low=%b extra requests=%0d, expected 1/0", oe_ok, en_cnt - n0);
        end
        bus.EBI_RE  = 1'b1;
        bus.EBI_ALE = 1'b0;
        repeat (5) @(negedge clk);

        latch_addr(16'h0040);
        bus.EBI_RE = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = bus.ebi_ad_oe;
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (got !== 1'b1 || bus.ebi_ad_oe !== 1'b0 || bus.ebi_ad_out !== 16'h0000 || bus.mem_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_drive: reached_drive=%b oe=%b out=%h en=%b, expected 1/0/0000/0",
                     got, bus.ebi_ad_oe, bus.ebi_ad_out, bus.mem_rd_en);
        end
        bus.EBI_RE = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [14:0] exp_a [3];
        logic [15:0] d;
        int          lat;
        logic        st, oh, oa;
`ifdef EBI_READ_AUTOINC_EN
        exp_a = '{15'h7FFE, 15'h7FFF, 15'h0000};
`else
        exp_a = '{15'h7FFE, 15'h7FFE, 15'h7FFE};
`endif
        do_reset();
        latch_addr(16'h7FFE);
        for (int i = 0; i < 3; i++) begin
            re_strobe(0, d, lat, st, oh, oa);
            vectors++;
            if (en_addr !== exp_a[i] || d !== mem_f(exp_a[i])) begin
                miscompares++;
                $display("FAIL strobe_%0d: addr=%h data=%h, expected addr=%h data=%h",
                         i, en_addr, d, exp_a[i], mem_f(exp_a[i]));
            end
        end
    endtask

    initial begin
        line_y      = 10'd0;
        vblank      = 1'b0;
        frame_tick  = 1'b0;
        test_reset();
        test_idle_read();
        test_mem_read();
        test_status();
        test_abort();
        test_back_to_back();
        test_frame_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
